apb_timer_master: RTL
=====================

Name: apb_timer_master

Overview:
- APB initiator (requester) that drives the timer peripheral's APB slave port: PSEL, PENABLE, PADDR, PWRITE, PWDATA.
- Converts a simple valid/ready command interface from the control logic into APB SETUP/ACCESS transfers.
- Returns read data and error status on a one-cycle response strobe.
- Replaces hand-sequenced PSEL/PENABLE stimulus with a reusable, protocol-correct requester.

Parameters:
- ADDR_W, 2: width of PADDR and cmd_addr.
- DATA_W, 8: width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT, 16: ACCESS cycles with PREADY low before abort. Used only when APB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- PCLK  in  1  single clock; all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  PSLVERR captured, or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready; tie high for zero-wait slaves.
- PSLVERR  in  1  slave error; tie low if unused.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset is asynchronous, active-low, on PRESETn.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0.
- All APB outputs and rsp_* outputs are registered.
- cmd_ready = (state == IDLE), decoded from the state register only, with no combinational path from cmd_valid.
- FSM states and transitions:
  - IDLE: on cmd_valid, register PADDR <= cmd_addr, PWRITE <= cmd_write, PWDATA <= cmd_wdata (0 on reads), PSEL <= 1. Go to SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then PENABLE <= 1. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Hold while PREADY=0. On PREADY=1:
    - capture rsp_rdata <= (PWRITE ? 0 : PRDATA) and rsp_err <= PSLVERR;
    - rsp_valid <= 1;
    - PSEL <= 0, PENABLE <= 0;
    - go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. After completion they hold their last values (no toggling in IDLE).
- Response timing:
  - rsp_valid is high for exactly one cycle: the first IDLE cycle after completion.
  - rsp_rdata and rsp_err hold until the next completion.
- Throughput and latency:
  - A new command may be accepted in the same cycle rsp_valid is high.
  - Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS); back-to-back zero-wait transfers every 3 cycles.
  - Latency from command acceptance to rsp_valid = 3 + wait states.
- PSEL never rises together with PENABLE. PENABLE is never high without PSEL.
- Commands presented outside IDLE are ignored, since cmd_ready=0. The requester must hold cmd_* stable until accepted.
- PSLVERR is sampled only in the ACCESS cycle where PREADY=1.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The FSM returns to IDLE, no rsp_valid is issued, and the transfer is lost.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT-1 with PREADY still 0, the transfer aborts: rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL/PENABLE drop, go to IDLE.
  - If PREADY=1 arrives in the same cycle, it wins: normal completion.
- Undefined: no counter is present; ACCESS waits indefinitely for PREADY. TIMEOUT is unused.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - default ADDR_W/DATA_W constants;
  - timer register address constants TIMER_ADDR_CTRL=2'd0 and TIMER_ADDR_LOAD=2'd1.
- One natural sub-module: apb_wait_timer, the timeout counter, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Reset, then write addr=1, data=8'h02, PREADY=1: SETUP cycle PSEL=1/PENABLE=0; next cycle PENABLE=1, PADDR=1, PWDATA=2, PWRITE=1; then rsp_valid=1, rsp_err=0, rsp_rdata=0. Total 3 cycles.
- Read addr=0 with PREADY low for 2 ACCESS cycles, PRDATA=8'hA5 on the ready cycle: PENABLE high for 3 cycles, PADDR stable throughout; rsp_rdata=8'hA5, latency 5 cycles.
- Two back-to-back writes (cmd_valid held, data 8'h11 then 8'h22): second SETUP occurs 3 cycles after the first; PSEL drops low for exactly 1 cycle between transfers.
- PSLVERR=1 with PREADY=1 on a read: rsp_err=1; the next transfer with PSLVERR=0 gives rsp_err=0.
- PRESETn deasserted during ACCESS: PSEL=0 and PENABLE=0 immediately, no rsp_valid; after reset release, cmd_ready=1.
- With APB_TIMEOUT_EN and TIMEOUT=4, PREADY held 0: abort after 4 ACCESS cycles with rsp_err=1, rsp_rdata=0. Without the macro, still waiting after 20 cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB timer requester: FSM state encoding,
// default bus widths and the timer peripheral's register map.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W = 2;
   localparam int APB_DATA_W = 8;

   localparam logic [APB_ADDR_W-1:0] TIMER_ADDR_CTRL = 2'd0;
   localparam logic [APB_ADDR_W-1:0] TIMER_ADDR_LOAD = 2'd1;

endpackage

// File: rtl/apb_timer_master_if.sv
// Command/response handshake plus APB bus between the control logic, the
// requester (master modport) and the timer peripheral (slave modport).
interface apb_timer_master_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter for the requester's timeout abort. Only compiled
// when APB_TIMEOUT_EN is defined; without it the requester waits forever.
`ifdef APB_TIMEOUT_EN
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Reaching LAST means TIMEOUT-1 stalled cycles have already elapsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (count_en)
         count <= count + CNT_W'(1);
   end

   assign expired = (count == LAST);

endmodule
`endif

// File: rtl/apb_timer_master.sv
// APB requester turning valid/ready commands into SETUP/ACCESS transfers.
// Optional wait-state timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_timer_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   apb_timer_master_if.master bus
);

   apb_state_e        state, state_next;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              abort;

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("apb_timer_master: TIMEOUT must be >= 2");
   end

`ifdef APB_TIMEOUT_EN
   logic wait_expired;

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk      (PCLK),
      .rst_n    (PRESETn),
      .clear    (state == SETUP),
      .count_en (state == ACCESS && !bus.PREADY),
      .expired  (wait_expired)
   );

   assign abort = wait_expired;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= state_next;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Address/direction/data only load in IDLE, so they stay put for the whole transfer.
   always_comb begin
      state_next  = state;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               paddr_d    = bus.cmd_addr;
               pwrite_d   = bus.cmd_write;
               pwdata_d   = bus.cmd_write ? bus.cmd_wdata : '0;
               psel_d     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            penable_d  = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
               rsp_err_d   = bus.PSLVERR;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_next  = IDLE;
            end else if (abort) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;

endmodule
